add_unit_arbiter: RTL and testbench
===================================

# add_unit_arbiter

Shares one `csa_32_bit` adder among `NUM_REQ` issue-side requesters, such as reservation stations or address-generation ports, in the out-of-order core. A round-robin arbiter accepts one request per cycle and latches it into a 2-stage pipeline (operands, then result). Results are delivered with their tag toward the common data bus over a valid/ready handshake with full backpressure.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TAG_W`, default 6: width of the ROB/RS tag.
- `SRC_W`, default 2: width of the requester index, equal to ceil(log2(NUM_REQ)).

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester request.
- `req_ready`  out  NUM_REQ: per-requester accept; at most one bit high.
- `req_a`  in  NUM_REQ*32: operand A; slice i is bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32: operand B, sliced the same way.
- `req_sub`  in  NUM_REQ: 1 = A−B, 0 = A+B.
- `req_tag`  in  NUM_REQ*TAG_W: destination tag.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_sum`  out  32: sum or difference.
- `res_cout`  out  1: adder carry-out.
- `res_ovf`  out  1: signed overflow.
- `res_tag`  out  TAG_W: tag of the result.
- `res_src`  out  SRC_W: index of the requester that was granted.

## Operation
- **Stage S1 (operand register):** holds `s1_valid`, A, B', sub, tag and src, where B' = sub ? ~B : B.
- **Stage S2 (result register):** holds the `csa_32_bit` output computed from S1, with Cin = sub.
- **Advance conditions:**
  - S2 loads when `s1_valid` && (!`res_valid` || `res_ready`).
  - S1 loads when (!`s1_valid` || S2 loads).
- **Grant:**
  - When S1 can load, `req_ready`[g] = 1 for the first set `req_valid` bit, searching circularly from `rr_ptr`.
  - When S1 cannot load, all `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Round-robin pointer:** on an accepted transfer to requester g, `rr_ptr` ← (g+1) mod NUM_REQ. Otherwise it holds.
- **Requester rule:** a requester keeps `req_valid` asserted and its data stable until it sees `req_ready`.
- **Overflow:** `res_ovf` = (A[31] == B'[31]) && (sum[31] != A[31]).
- **Carry:** `res_cout` is the raw adder carry. For subtraction, 1 means no borrow.
- **Arithmetic width:** all arithmetic is modulo 2^32 with no saturation.
- **Reset:**
  - `rr_ptr` = 0, `s1_valid` = 0, `res_valid` = 0.
  - `res_sum`, `res_cout`, `res_ovf`, `res_tag` and `res_src` reset to 0.
  - `req_ready` is 0 while `reset_n` is low.
  - Reset mid-operation discards both in-flight entries with no result emitted.

## Timing
- **Latency:** a request accepted at edge k gives S1 at k and `res_valid` = 1 from edge k+1. That is 2 edges from grant to result.
- **Throughput:** one operation per cycle while `res_ready` = 1.
- **Backpressure:**
  - With `res_valid` && !`res_ready`, S2 holds and its outputs are stable.
  - S1 holds when it is full.
  - `req_ready` is all-zero while both stages are full.
- **Simultaneous drain and refill:** with S1 full, S2 full and `res_ready` = 1 in the same cycle, S2 takes S1 and S1 takes the new grant. There is no bubble.
- **Idle:** with no valid requests, `rr_ptr` does not move and `s1_valid` clears once S2 loads.
- **Boundaries:**
  - The pointer wraps from NUM_REQ−1 to 0.
  - A single requester that is always valid is granted every cycle.

## Configuration
- **`ADD_ARB_PERF_EN` defined:** adds the following outputs. Both counters reset to 0.
  - `perf_ops` (32): increments on every `res_valid` && `res_ready` handshake.
  - `perf_stall` (32): increments on every cycle where some `req_valid` is high but no `req_ready` is high.
  - Both counters saturate at 0xFFFFFFFF.
- **`ADD_ARB_PERF_EN` not defined:** the ports and counters are absent and the datapath behaviour is identical.

## Test plan
- **Reset:** assert `reset_n` = 0 with all `req_valid` = 1 → `req_ready` = 0, `res_valid` = 0, and all outputs are 0.
- **Single add:** req0 sends A = 0x7FFFFFFF, B = 1, add, tag = 5 → two edges later `res_sum` = 0x80000000, `res_ovf` = 1, `res_cout` = 0, `res_tag` = 5, `res_src` = 0.
- **Subtract:** req2 sends A = 3, B = 5, sub → `res_sum` = 0xFFFFFFFE, `res_cout` = 0, `res_ovf` = 0. Then A = 0x80000000, B = 1 → `res_sum` = 0x7FFFFFFF, `res_ovf` = 1, `res_cout` = 1.
- **Round-robin:** all 4 requesters held valid, `res_ready` = 1 → grant order 0,1,2,3,0, with `res_src` in the same order and one result per cycle.
- **Backpressure:** hold `res_ready` = 0 for 5 cycles → the first result stays stable and `req_ready` = 0 after S1 fills. Release `res_ready` → results follow on consecutive cycles in grant order with no loss or duplication.
- **Mid-stream reset:** assert `reset_n` low while S1 and S2 are full → `res_valid` drops immediately (asynchronously). After release, the next grant goes to req0.

Source files
------------

// File: rtl/add_unit_arbiter.sv
// add_unit_arbiter: round-robin arbiter that shares one csa_32_bit adder.
// Requests arrive on req_* (valid/ready). Granted operands go into S1, and
// results go into S2. Results leave on res_* (valid/ready) toward the CDB.
// Optional: define ADD_ARB_PERF_EN to add the perf_ops/perf_stall outputs.

module csa_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // 4-bit carry-select blocks: each block precomputes both carry cases.
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar k = 0; k < 8; k++) begin : g_blk
        logic [4:0] s0;
        logic [4:0] s1;
        assign s0 = {1'b0, a[4*k+3:4*k]} + {1'b0, b[4*k+3:4*k]};
        assign s1 = {1'b0, a[4*k+3:4*k]} + {1'b0, b[4*k+3:4*k]} + 5'd1;
        assign sum[4*k+3:4*k] = c[k] ? s1[3:0] : s0[3:0];
        assign c[k+1] = c[k] ? s1[4] : s0[4];
    end

    assign cout = c[8];

endmodule

module add_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int SRC_W   = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_sum,
    output logic                     res_cout,
    output logic                     res_ovf,
    output logic [TAG_W-1:0]         res_tag,
    output logic [SRC_W-1:0]         res_src
`ifdef ADD_ARB_PERF_EN
    ,
    output logic [31:0]              perf_ops,
    output logic [31:0]              perf_stall
`endif
);

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q, s1_a_d;
    logic [31:0]      s1_b_q, s1_b_d;
    logic             s1_sub_q, s1_sub_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [SRC_W-1:0] s1_src_q, s1_src_d;

    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_ovf_q, res_ovf_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [SRC_W-1:0] res_src_q, res_src_d;

    logic             s2_load;
    logic             s1_load;
    logic             gnt_found;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W:0]   scan;
    logic             accept;

    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_sub;
    logic [TAG_W-1:0] sel_tag;

    logic [31:0]      add_sum;
    logic             add_cout;

    // Pipeline advance and circular first-one search from rr_ptr.
    always_comb begin
        s2_load   = s1_valid_q && (!res_valid_q || res_ready);
        s1_load   = !s1_valid_q || s2_load;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
            if (scan >= (SRC_W+1)'(NUM_REQ)) begin
                scan = scan - (SRC_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[scan[SRC_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[SRC_W-1:0];
            end
        end
    end

    // Ready is gated by reset so that no requester sees a phantom accept.
    assign accept = gnt_found && s1_load && reset_n;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_sub   = 1'b0;
        sel_tag   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == gnt_idx) begin
                req_ready[i] = accept;
                sel_a        = req_a[i*32 +: 32];
                sel_b        = req_b[i*32 +: 32];
                sel_sub      = req_sub[i];
                sel_tag      = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (gnt_idx == SRC_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + SRC_W'(1);
            end
        end
    end

    // S1 stores B already inverted for subtract; the adder adds Cin = sub.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sub_d   = s1_sub_q;
        s1_tag_d   = s1_tag_q;
        s1_src_d   = s1_src_q;
        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d   = sel_a;
                s1_b_d   = sel_sub ? ~sel_b : sel_b;
                s1_sub_d = sel_sub;
                s1_tag_d = sel_tag;
                s1_src_d = gnt_idx;
            end
        end
    end

    csa_32_bit u_csa (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .cin  (s1_sub_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        res_tag_d   = res_tag_q;
        res_src_d   = res_src_q;
        if (s2_load) begin
            res_valid_d = 1'b1;
            res_sum_d   = add_sum;
            res_cout_d  = add_cout;
            res_ovf_d   = (s1_a_q[31] == s1_b_q[31]) &&
                          (add_sum[31] != s1_a_q[31]);
            res_tag_d   = s1_tag_q;
            res_src_d   = s1_src_q;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sub_q    <= 1'b0;
            s1_tag_q    <= '0;
            s1_src_q    <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_tag_q   <= '0;
            res_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sub_q    <= s1_sub_d;
            s1_tag_q    <= s1_tag_d;
            s1_src_q    <= s1_src_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            res_tag_q   <= res_tag_d;
            res_src_q   <= res_src_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;
    assign res_tag   = res_tag_q;
    assign res_src   = res_src_q;

`ifdef ADD_ARB_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Both counters saturate instead of wrapping.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (res_valid_q && res_ready && perf_ops_q != 32'hFFFF_FFFF) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if ((|req_valid) && !(|req_ready) &&
            perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_add_unit_arbiter.sv
// tb_add_unit_arbiter: directed and random stimulus for add_unit_arbiter,
// scored against a transaction-level model of grants and results.

module tb_add_unit_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int SW = 2;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_sub;
    logic [N*TW-1:0] req_tag;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_sum;
    logic            res_cout;
    logic            res_ovf;
    logic [TW-1:0]   res_tag;
    logic [SW-1:0]   res_src;

    always #5 clock = ~clock;

    add_unit_arbiter #(.NUM_REQ(N), .TAG_W(TW), .SRC_W(SW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .res_tag   (res_tag),
        .res_src   (res_src)
    );

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic          sub;
        logic [TW-1:0] tag;
    } op_t;

    typedef struct {
        logic [31:0]   sum;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
        logic [SW-1:0] src;
    } res_t;

    op_t          op[N];
    logic [N-1:0] vld;
    int           rearm_mode;
    int           arrive_pct;
    bit           rand_rdy;

    bit   m1v, m2v;
    res_t m1, m2;
    int   rr;

    res_t got_q[$];
    int   gnt_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check_eq(string tag, logic [63:0] got,
                            logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model_res(op_t o, int src);
        res_t        r;
        longint      sa, sb, s;
        logic [32:0] u;
        sa = longint'($signed(o.a));
        sb = longint'($signed(o.b));
        if (o.sub) begin
            r.sum  = o.a - o.b;
            r.cout = (o.a >= o.b);
            s      = sa - sb;
        end else begin
            u      = {1'b0, o.a} + {1'b0, o.b};
            r.sum  = u[31:0];
            r.cout = u[32];
            s      = sa + sb;
        end
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.tag = o.tag;
        r.src = SW'(src);
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  c;
        c = int'($urandom % 8);
        o.a = (c == 0) ? 32'h7FFF_FFFF :
              (c == 1) ? 32'h8000_0000 :
              (c == 2) ? 32'hFFFF_FFFF : 32'($urandom);
        c = int'($urandom % 8);
        o.b = (c == 0) ? 32'h0000_0001 :
              (c == 1) ? 32'h8000_0000 :
              (c == 2) ? 32'h0000_0000 : 32'($urandom);
        o.sub = 1'($urandom);
        o.tag = TW'($urandom);
        return o;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = vld[i];
            req_a[i*32 +: 32]     = op[i].a;
            req_b[i*32 +: 32]     = op[i].b;
            req_sub[i]            = op[i].sub;
            req_tag[i*TW +: TW]   = op[i].tag;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int           g;
        bit           can;
        res_t         r;
        @(negedge clock);
        exp_rdy = '0;
        g       = -1;
        can     = 1'b0;
        if (reset_n) begin
            can = !m1v || !m2v || res_ready;
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (rr + k) % N;
                    if (g < 0 && vld[j]) g = j;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        check_eq("res_valid", 64'(res_valid), 64'(m2v));
        if (m2v && res_valid) begin
            check_eq("res_sum", 64'(res_sum), 64'(m2.sum));
            check_eq("res_cout", 64'(res_cout), 64'(m2.cout));
            check_eq("res_ovf", 64'(res_ovf), 64'(m2.ovf));
            check_eq("res_tag", 64'(res_tag), 64'(m2.tag));
            check_eq("res_src", 64'(res_src), 64'(m2.src));
        end
        if (res_valid && res_ready) begin
            r.sum  = res_sum;
            r.cout = res_cout;
            r.ovf  = res_ovf;
            r.tag  = res_tag;
            r.src  = res_src;
            got_q.push_back(r);
        end
        @(posedge clock);
        if (reset_n) begin
            if (m1v && (!m2v || res_ready)) begin
                m2  = m1;
                m2v = 1'b1;
            end else if (res_ready) begin
                m2v = 1'b0;
            end
            if (can) begin
                m1v = (g >= 0);
                if (g >= 0) begin
                    m1 = model_res(op[g], g);
                    gnt_q.push_back(g);
                    rr = (g + 1) % N;
                end
            end
        end
        #1;
        if (reset_n && can && g >= 0) begin
            if (rearm_mode == 1 ||
                (rearm_mode == 2 && $urandom % 2 == 0)) begin
                op[g] = rand_op();
                vld[g] = 1'b1;
            end else begin
                vld[g] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && int'($urandom % 100) < arrive_pct) begin
                op[i]  = rand_op();
                vld[i] = 1'b1;
            end
        end
        if (rand_rdy) res_ready = ($urandom % 4) != 0;
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_valid", 64'(res_valid), 64'd0);
        check_eq("rst_async_ready", 64'(req_ready), 64'd0);
        m1v = 1'b0;
        m2v = 1'b0;
        rr  = 0;
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    task automatic set_op(int i, logic [31:0] a, logic [31:0] b,
                          logic s, logic [TW-1:0] t);
        op[i].a   = a;
        op[i].b   = b;
        op[i].sub = s;
        op[i].tag = t;
        vld[i]    = 1'b1;
        drive();
    endtask

    task automatic check_res(string tag, logic [31:0] sum, logic cout,
                             logic ovf, logic [TW-1:0] t, int src);
        res_t r;
        check_eq({tag, "_count"}, 64'(got_q.size()), 64'd1);
        if (got_q.size() != 0) begin
            r = got_q.pop_front();
            check_eq({tag, "_sum"}, 64'(r.sum), 64'(sum));
            check_eq({tag, "_cout"}, 64'(r.cout), 64'(cout));
            check_eq({tag, "_ovf"}, 64'(r.ovf), 64'(ovf));
            check_eq({tag, "_tag"}, 64'(r.tag), 64'(t));
            check_eq({tag, "_src"}, 64'(r.src), 64'(src));
        end
        got_q.delete();
    endtask

    initial begin
        res_t saved;
        int   n;
        for (int i = 0; i < N; i++) op[i] = '{default: '0};
        vld        = '1;
        rearm_mode = 0;
        arrive_pct = 0;
        rand_rdy   = 1'b0;
        res_ready  = 1'b1;
        m1v        = 1'b0;
        m2v        = 1'b0;
        rr         = 0;
        drive();

        // Reset with every requester asserting valid.
        repeat (3) cycle();
        check_eq("rst_sum", 64'(res_sum), 64'd0);
        check_eq("rst_cout", 64'(res_cout), 64'd0);
        check_eq("rst_ovf", 64'(res_ovf), 64'd0);
        check_eq("rst_tag", 64'(res_tag), 64'd0);
        check_eq("rst_src", 64'(res_src), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        vld = '0;
        drive();
        reset_n = 1'b1;
        got_q.delete();
        gnt_q.delete();

        // Single add with signed overflow.
        set_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, TW'(5));
        repeat (4) cycle();
        check_res("add", 32'h8000_0000, 1'b0, 1'b1, TW'(5), 0);

        // Subtracts on requester 2.
        set_op(2, 32'd3, 32'd5, 1'b1, TW'(9));
        repeat (4) cycle();
        check_res("sub1", 32'hFFFF_FFFE, 1'b0, 1'b0, TW'(9), 2);
        set_op(2, 32'h8000_0000, 32'h1, 1'b1, TW'(10));
        repeat (4) cycle();
        check_res("sub2", 32'h7FFF_FFFF, 1'b1, 1'b1, TW'(10), 2);

        // Round-robin from a freshly reset pointer.
        do_reset();
        got_q.delete();
        gnt_q.delete();
        rearm_mode = 1;
        for (int i = 0; i < N; i++) op[i] = rand_op();
        vld = '1;
        res_ready = 1'b1;
        drive();
        repeat (7) cycle();
        for (int k = 0; k < 5; k++) begin
            check_eq("rr_grant", 64'(gnt_q[k]), 64'(k % N));
            check_eq("rr_src", 64'(got_q[k].src), 64'(k % N));
        end

        // Backpressure: hold the consumer off for five cycles.
        res_ready = 1'b0;
        saved = m2;
        repeat (5) cycle();
        check_eq("bp_sum_hold", 64'(res_sum), 64'(saved.sum));
        check_eq("bp_tag_hold", 64'(res_tag), 64'(saved.tag));
        check_eq("bp_ready_zero", 64'(req_ready), 64'd0);
        res_ready = 1'b1;
        repeat (6) cycle();
        rearm_mode = 0;
        vld = '0;
        drive();
        repeat (4) cycle();
        check_eq("bp_count", 64'(got_q.size()), 64'(gnt_q.size()));
        n = (got_q.size() < gnt_q.size()) ? got_q.size() : gnt_q.size();
        for (int k = 0; k < n; k++) begin
            check_eq("bp_order", 64'(got_q[k].src), 64'(gnt_q[k]));
        end
        got_q.delete();
        gnt_q.delete();

        // Random traffic with random backpressure.
        rearm_mode = 2;
        arrive_pct = 40;
        rand_rdy   = 1'b1;
        repeat (600) cycle();
        rearm_mode = 0;
        arrive_pct = 0;
        rand_rdy   = 1'b0;
        res_ready  = 1'b1;
        vld = '0;
        drive();
        repeat (4) cycle();
        check_eq("rand_count", 64'(got_q.size()), 64'(gnt_q.size()));
        got_q.delete();
        gnt_q.delete();

        // Mid-stream reset with both stages full.
        rearm_mode = 1;
        for (int i = 0; i < N; i++) op[i] = rand_op();
        vld = '1;
        res_ready = 1'b0;
        drive();
        repeat (3) cycle();
        check_eq("mid_full", 64'(res_valid), 64'd1);
        do_reset();
        gnt_q.delete();
        res_ready = 1'b1;
        cycle();
        check_eq("mid_gnt_cnt", 64'(gnt_q.size()), 64'd1);
        if (gnt_q.size() != 0) begin
            check_eq("mid_gnt0", 64'(gnt_q[0]), 64'd0);
        end
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
